// File: rtl/imu_i2c_responder.sv
// imu_i2c_responder: I2C target exposing a 128x8 register file with a fixed chip ID at 0x00.
module imu_i2c_responder #(
    parameter logic [6:0] I2C_ADDR = 7'h28,
    parameter logic [7:0] CHIP_ID  = 8'hA0
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       load_en,
    input  logic [6:0] load_addr,
    input  logic [7:0] load_data,
    output logic       bus_wr_strobe,
    output logic [6:0] bus_wr_addr,
    output logic [7:0] bus_wr_data,
    output logic       busy
);
    typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, IGNORE} state_t;
    state_t     r_state;
    logic       r_scl_s1, r_scl_s2, r_scl_d, r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0] r_cnt;
    logic [7:0] r_shift, r_tx;
    logic [6:0] r_ptr;
    logic       r_rw, r_nack;
    logic [7:0] r_mem [0:127];
    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_byte_end, w_bus_we;
    logic [7:0] w_rd_byte;
    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte_end = w_scl_fall & (r_cnt == 4'd8);
    assign w_bus_we   = (r_state == WDATA) & w_byte_end & (r_ptr != 7'd0);
    assign w_rd_byte  = (r_ptr == 7'd0) ? CHIP_ID : r_mem[r_ptr];
    // Bus write is issued last so it overrides a same-cycle local load to the same address.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) r_mem[i] <= 8'h00;
        end else begin
            if (load_en && load_addr != 7'd0) r_mem[load_addr] <= load_data;
            if (w_bus_we) r_mem[r_ptr] <= r_shift;
        end
    end
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            {r_scl_s1, r_scl_s2, r_scl_d, r_sda_s1, r_sda_s2, r_sda_d} <= 6'h3F;
            r_state       <= IDLE;
            sda_oe        <= 1'b0;
            busy          <= 1'b0;
            bus_wr_strobe <= 1'b0;
            bus_wr_addr   <= 7'd0;
            bus_wr_data   <= 8'd0;
            r_ptr         <= 7'd0;
            r_cnt         <= 4'd0;
            r_shift       <= 8'd0;
            r_tx          <= 8'd0;
            r_rw          <= 1'b0;
            r_nack        <= 1'b0;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_in, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_in, r_sda_s1, r_sda_s2};
            bus_wr_strobe <= 1'b0;
            if (w_start) begin
                r_state <= ADDR;
                r_cnt   <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (w_scl_rise) begin
                case (r_state)
                    ADDR, PTR, WDATA: begin
                        r_shift <= {r_shift[6:0], r_sda_s2};
                        r_cnt   <= r_cnt + 4'd1;
                    end
                    RDATA:   r_cnt  <= r_cnt + 4'd1;
                    RACK:    r_nack <= r_sda_s2;
                    default: ;
                endcase
            end else if (w_scl_fall) begin
                case (r_state)
                    ADDR: if (w_byte_end) begin
                        r_cnt <= 4'd0;
                        if (r_shift[7:1] == I2C_ADDR) begin
                            r_state <= ADDR_ACK;
                            sda_oe  <= 1'b1;
                            busy    <= 1'b1;
                            r_rw    <= r_shift[0];
                        end else r_state <= IGNORE;
                    end
                    PTR: if (w_byte_end) begin
                        r_ptr   <= r_shift[6:0];
                        r_cnt   <= 4'd0;
                        r_state <= PTR_ACK;
                        sda_oe  <= 1'b1;
                    end
                    WDATA: if (w_byte_end) begin
                        r_cnt   <= 4'd0;
                        r_state <= WACK;
                        sda_oe  <= 1'b1;
                        r_ptr   <= r_ptr + 7'd1;
                        if (r_ptr != 7'd0) begin
                            bus_wr_strobe <= 1'b1;
                            bus_wr_addr   <= r_ptr;
                            bus_wr_data   <= r_shift;
                        end
                    end
                    ADDR_ACK: begin
                        r_state <= r_rw ? RDATA : PTR;
                        sda_oe  <= r_rw & ~w_rd_byte[7];
                        r_tx    <= {w_rd_byte[6:0], 1'b0};
                    end
                    PTR_ACK, WACK: begin
                        r_state <= WDATA;
                        sda_oe  <= 1'b0;
                    end
                    RDATA: begin
                        if (r_cnt == 4'd8) begin
                            r_state <= RACK;
                            sda_oe  <= 1'b0;
                            r_cnt   <= 4'd0;
                            r_ptr   <= r_ptr + 7'd1;
                        end else begin
                            sda_oe <= ~r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                    end
                    RACK: begin
                        r_state <= r_nack ? IGNORE : RDATA;
                        sda_oe  <= ~r_nack & ~w_rd_byte[7];
                        r_tx    <= {w_rd_byte[6:0], 1'b0};
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
